stream_rr_arbiter: RTL and testbench
====================================

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WD, default 4, payload width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports s0_valid/s1_valid  input  1  each source beat valid.
REQ-005 SHALL have ports s0_data/s1_data  input  DATA_WD  each source payload.
REQ-006 SHALL have ports s0_last/s1_last  input  1  each source end-of-packet marker.
REQ-007 SHALL have ports s0_ready/s1_ready  output  1  each source beat accepted when valid&&ready.
REQ-008 SHALL have port m_valid  output  1  registered output beat valid.
REQ-009 SHALL have port m_data  output  DATA_WD  registered output payload.
REQ-010 SHALL have port m_last  output  1  registered end-of-packet marker.
REQ-011 SHALL have port m_sel  output  1  source index (0/1) of the beat in m_data.
REQ-012 SHALL have port m_ready  input  1  downstream accept; output fires on m_valid&&m_ready.

Function
REQ-013 SHALL define load_en = !m_valid || m_ready; no source is ready when load_en=0.
REQ-014 SHALL keep a 1-bit priority pointer ptr; in IDLE, grant goes to source ptr if valid, else to the other source if valid, else none.
REQ-015 SHALL assert sX_ready combinationally = load_en && (grant==X); at most one sX_ready high per cycle.
REQ-016 SHALL, on an accepted beat, load m_data/m_last/m_sel from the granted source and set m_valid=1 at the next edge (latency 1 cycle).
REQ-017 SHALL clear m_valid at the edge where m_valid&&m_ready and no new beat is accepted; fire-and-accept in the same cycle SHALL sustain one beat per cycle.
REQ-018 SHALL hold m_data/m_last/m_sel stable while m_valid=1 and m_ready=0.
REQ-019 SHALL implement states IDLE and LOCK; LOCK stores owner index.
REQ-020 SHALL transition IDLE->LOCK on an accepted beat with last=0; owner = granted source.
REQ-021 SHALL, in LOCK, grant only the owner regardless of the other source's valid or ptr.
REQ-022 SHALL transition LOCK->IDLE on an accepted owner beat with last=1.
REQ-023 SHALL set ptr = ~granted index at the edge where a grant ends (accepted beat with last=1); single-beat packets in IDLE end grant immediately.
REQ-024 SHALL not change state or ptr when no beat is accepted, including owner bubbles (owner valid=0) in LOCK.
REQ-025 SHALL, with both sources continuously valid, alternate packets 0,1,0,1 starting with source 0 after reset.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set m_valid=0, m_data=0, m_last=0, m_sel=0, state=IDLE, owner=0, ptr=0.
REQ-027 SHALL hold s0_ready=s1_ready=0 while rst=1.
REQ-028 SHALL, on reset mid-packet, drop the in-flight beat and lock; first post-reset grant follows ptr=0.

Configuration
REQ-029 SHALL use macro STREAM_ARB_PKT_LOCK_EN to compile packet locking in or out.
REQ-030 SHALL, with STREAM_ARB_PKT_LOCK_EN defined, behave per REQ-019..REQ-025.
REQ-031 SHALL, without STREAM_ARB_PKT_LOCK_EN, omit LOCK state: every accepted beat ends its grant and toggles ptr per REQ-023 irrespective of last; last is passed through to m_last unchanged.

Verification
REQ-032 SHALL cover: rst=1 for 3 cycles with s0_valid=s1_valid=1 -> s0_ready=s1_ready=0, m_valid=0, m_sel=0.
REQ-033 SHALL cover: both sources valid, 3-beat packets (data 1,2,3 on s0; 9,A,B on s1), m_ready=1, lock enabled -> m_data 1,2,3,9,A,B with m_sel 0,0,0,1,1,1, one beat per cycle, first m_valid one cycle after first accept.
REQ-034 SHALL cover: same stimulus, lock disabled -> m_data 1,9,2,A,3,B with m_sel alternating 0,1.
REQ-035 SHALL cover: m_ready=0 for 4 cycles with m_valid=1 data 5 -> m_data=5 held, s0_ready=s1_ready=0, then one fire on m_ready=1.
REQ-036 SHALL cover: s0 locked after beat last=0, s0_valid drops 2 cycles while s1_valid=1 -> s1_ready stays 0, s0 resumes and finishes before s1 is granted.
REQ-037 SHALL cover: rst pulsed 1 cycle mid-packet from s1 -> m_valid=0 next cycle, state IDLE, next grant to s0 when both valid.

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// Two-source round-robin stream arbiter with a registered output stage.
// Define STREAM_ARB_PKT_LOCK_EN to hold a grant for a whole packet (until a beat with last=1).
module stream_rr_arbiter #(
  parameter int DATA_WD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s0_valid,
  input  logic [DATA_WD-1:0] s0_data,
  input  logic               s0_last,
  output logic               s0_ready,
  input  logic               s1_valid,
  input  logic [DATA_WD-1:0] s1_data,
  input  logic               s1_last,
  output logic               s1_ready,
  output logic               m_valid,
  output logic [DATA_WD-1:0] m_data,
  output logic               m_last,
  output logic               m_sel,
  input  logic               m_ready
);

  logic               load_en;
  logic               idle_grant_vld;
  logic               idle_grant;
  logic               grant_vld;
  logic               grant;
  logic               sel_valid;
  logic [DATA_WD-1:0] sel_data;
  logic               sel_last;
  logic               accept;
  logic               ptr;
  logic               ptr_nxt;

`ifdef STREAM_ARB_PKT_LOCK_EN
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   owner;
  logic   owner_nxt;
`endif

  // The output register can take a new beat when empty or draining this cycle.
  assign load_en = !m_valid || m_ready;

  // Round-robin choice used whenever no packet holds the grant.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    idle_grant_vld = 1'b0;
    idle_grant     = ptr;
    if (ptr ? s1_valid : s0_valid) begin
      idle_grant_vld = 1'b1;
      idle_grant     = ptr;
    end else if (ptr ? s0_valid : s1_valid) begin
      idle_grant_vld = 1'b1;
      idle_grant     = ~ptr;
    end
  end

`ifdef STREAM_ARB_PKT_LOCK_EN
  // A locked owner keeps the grant even through its own bubbles.
  assign grant_vld = (state == LOCK) ? 1'b1  : idle_grant_vld;
  assign grant     = (state == LOCK) ? owner : idle_grant;
`else
  assign grant_vld = idle_grant_vld;
  assign grant     = idle_grant;
`endif

  assign sel_valid = grant ? s1_valid : s0_valid;
  assign sel_data  = grant ? s1_data  : s0_data;
  assign sel_last  = grant ? s1_last  : s0_last;

  assign s0_ready = !rst && load_en && grant_vld && !grant;
  assign s1_ready = !rst && load_en && grant_vld &&  grant;
  assign accept   = (s0_valid && s0_ready) || (s1_valid && s1_ready);

  always_comb begin
    ptr_nxt   = ptr;
`ifdef STREAM_ARB_PKT_LOCK_EN
    state_nxt = state;
    owner_nxt = owner;
    if (accept) begin
      if (sel_last) begin
        state_nxt = IDLE;
        ptr_nxt   = ~grant;
      end else begin
        state_nxt = LOCK;
        owner_nxt = grant;
      end
    end
`else
    if (accept) begin
      ptr_nxt = ~grant;
    end
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      ptr   <= 1'b0;
`ifdef STREAM_ARB_PKT_LOCK_EN
      state <= IDLE;
      owner <= 1'b0;
`endif
    end else begin
      ptr   <= ptr_nxt;
`ifdef STREAM_ARB_PKT_LOCK_EN
      state <= state_nxt;
      owner <= owner_nxt;
`endif
    end
  end

  // Output stage: payload only moves on an accepted beat, so it holds during back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_sel   <= 1'b0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_data  <= sel_data;
      m_last  <= sel_last;
      m_sel   <= grant;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: source drivers feed beat queues, a monitor checks every output fire.
// Expectations follow the build: packet locking when STREAM_ARB_PKT_LOCK_EN is defined, per-beat round robin otherwise.
module tb_stream_rr_arbiter;

  localparam int DATA_WD = 4;

  typedef struct {
    logic [DATA_WD-1:0] data;
    logic               last;
  } src_beat_t;

  typedef struct {
    logic [DATA_WD-1:0] data;
    logic               last;
    logic               sel;
  } out_beat_t;

  logic               clk;
  logic               rst;
  logic               s0_valid;
  logic [DATA_WD-1:0] s0_data;
  logic               s0_last;
  logic               s0_ready;
  logic               s1_valid;
  logic [DATA_WD-1:0] s1_data;
  logic               s1_last;
  logic               s1_ready;
  logic               m_valid;
  logic [DATA_WD-1:0] m_data;
  logic               m_last;
  logic               m_sel;
  logic               m_ready;

  src_beat_t q0[$];
  src_beat_t q1[$];
  out_beat_t exp_q[$];
  logic      en0;
  logic      en1;
  int        n_checks;
  int        n_pass;
  int        fires;

  stream_rr_arbiter #(.DATA_WD(DATA_WD)) dut (
    .clk      (clk),
    .rst      (rst),
    .s0_valid (s0_valid),
    .s0_data  (s0_data),
    .s0_last  (s0_last),
    .s0_ready (s0_ready),
    .s1_valid (s1_valid),
    .s1_data  (s1_data),
    .s1_last  (s1_last),
    .s1_ready (s1_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_sel    (m_sel),
    .m_ready  (m_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic push_src(input int s, input int d, input bit l);
    src_beat_t b;
    b.data = d[DATA_WD-1:0];
    b.last = l;
    if (s == 0) q0.push_back(b);
    else q1.push_back(b);
  endtask

  task automatic expect_beat(input int d, input bit l, input bit s);
    out_beat_t b;
    b.data = d[DATA_WD-1:0];
    b.last = l;
    b.sel  = s;
    exp_q.push_back(b);
  endtask

  // Controls change one time unit after a falling edge; drivers and monitor sample a unit later.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < max_cycles) begin
      step(1);
      i++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  // Source driver: pops the front beat on acceptance, presents the next one after the rising edge.
  initial begin
    logic acc0;
    logic acc1;
    s0_valid = 1'b0;
    s0_data  = '0;
    s0_last  = 1'b0;
    s1_valid = 1'b0;
    s1_data  = '0;
    s1_last  = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      acc0 = s0_valid && s0_ready;
      acc1 = s1_valid && s1_ready;
      @(posedge clk);
      #1;
      if (acc0 && q0.size() != 0) void'(q0.pop_front());
      if (acc1 && q1.size() != 0) void'(q1.pop_front());
      s0_valid = en0 && (q0.size() != 0);
      s1_valid = en1 && (q1.size() != 0);
      if (q0.size() != 0) begin
        s0_data = q0[0].data;
        s0_last = q0[0].last;
      end
      if (q1.size() != 0) begin
        s1_data = q1[0].data;
        s1_last = q1[0].last;
      end
    end
  end

  // Monitor: every output fire must match the head of the scoreboard.
  initial begin
    out_beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && m_valid === 1'b1 && m_ready === 1'b1) begin
        fires++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {m_data, m_last, m_sel}, -1);
        end else begin
          e = exp_q.pop_front();
          check("beat", {m_data, m_last, m_sel}, {e.data, e.last, e.sel});
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1);
  end

  initial begin
    int f0;
    n_checks = 0;
    n_pass   = 0;
    fires    = 0;
    rst      = 1'b1;
    m_ready  = 1'b1;
    en0      = 1'b1;
    en1      = 1'b1;

    // Reset with both sources valid: no ready, empty output.
    push_src(0, 'h1, 0); push_src(0, 'h2, 0); push_src(0, 'h3, 1);
    push_src(1, 'h9, 0); push_src(1, 'hA, 0); push_src(1, 'hB, 1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("rst_s0_ready", s0_ready, 0);
      check("rst_s1_ready", s1_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_sel", m_sel, 0);
    end

    // Two 3-beat packets, both valid, full throughput.
`ifdef STREAM_ARB_PKT_LOCK_EN
    expect_beat('h1, 0, 0); expect_beat('h2, 0, 0); expect_beat('h3, 1, 0);
    expect_beat('h9, 0, 1); expect_beat('hA, 0, 1); expect_beat('hB, 1, 1);
`else
    expect_beat('h1, 0, 0); expect_beat('h9, 0, 1); expect_beat('h2, 0, 0);
    expect_beat('hA, 0, 1); expect_beat('h3, 1, 0); expect_beat('hB, 1, 1);
`endif
    f0  = fires;
    rst = 1'b0;
    step(7);
    check("burst_fire_count", fires - f0, 6);
    check("burst_left", exp_q.size(), 0);
    drain(5);

    // Back-pressure: beat 5 must hold for 4 stalled cycles with no source ready.
    m_ready = 1'b0;
    push_src(0, 'h5, 1);
    push_src(1, 'h7, 1);
    expect_beat('h5, 1, 0);
    expect_beat('h7, 1, 1);
    step(1);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("stall_m_valid", m_valid, 1);
      check("stall_m_data", m_data, 'h5);
      check("stall_s0_ready", s0_ready, 0);
      check("stall_s1_ready", s1_ready, 0);
    end
    m_ready = 1'b1;
    drain(10);

    // Owner bubble: s0 pauses for two cycles after a non-last beat.
    push_src(0, 'h4, 0);
    push_src(0, 'h5, 1);
    push_src(1, 'h8, 1);
`ifdef STREAM_ARB_PKT_LOCK_EN
    expect_beat('h4, 0, 0); expect_beat('h5, 1, 0); expect_beat('h8, 1, 1);
`else
    expect_beat('h4, 0, 0); expect_beat('h8, 1, 1); expect_beat('h5, 1, 0);
`endif
    step(1);
    en0 = 1'b0;
    step(1);
`ifdef STREAM_ARB_PKT_LOCK_EN
    check("bubble1_s1_ready", s1_ready, 0);
`else
    check("bubble1_s1_ready", s1_ready, 1);
`endif
    step(1);
    check("bubble2_s1_ready", s1_ready, 0);
    en0 = 1'b1;
    drain(20);

    // Reset mid-packet from s1: the held beat is dropped and s0 wins the next grant.
    m_ready = 1'b0;
    en0     = 1'b0;
    push_src(1, 'hC, 0);
    push_src(1, 'hD, 1);
    push_src(0, 'h6, 1);
    step(2);
    check("pre_rst_m_sel", m_sel, 1);
    rst = 1'b1;
    en0 = 1'b1;
    step(1);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_m_sel", m_sel, 0);
    check("midrst_s0_ready", s0_ready, 0);
    check("midrst_s1_ready", s1_ready, 0);
    rst     = 1'b0;
    m_ready = 1'b1;
    expect_beat('h6, 1, 0);
    expect_beat('hD, 1, 1);
    #1;
    check("post_rst_s0_ready", s0_ready, 1);
    check("post_rst_s1_ready", s1_ready, 0);
    drain(10);

    step(3);
    check("final_left", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
